// File: rtl/vga_console_writer.sv
// Text-console writer: turns a byte stream into single-byte writes to a COLS x ROWS
// character buffer, with cursor tracking, scrolling-free row wrap and screen clears.
module vga_console_writer #(
   parameter int          COLS  = 80,
   parameter int          ROWS  = 30,
   parameter logic [7:0]  BLANK = 8'h20
) (
   input  logic        Hclock,
   input  logic        Hreset,
   input  logic        ch_valid,
   input  logic [7:0]  ch_data,
   output logic        ch_ready,
   input  logic        clr_req,
   output logic        Hselect,
   output logic        Hwrite,
   output logic        Hsize,
   output logic        ready,
   output logic [11:0] Haddress,
   output logic [31:0] Hwritedata,
   output logic [6:0]  cursor_x,
   output logic [4:0]  cursor_y
);

   localparam logic [1:0] CLRSCR = 2'd0;
   localparam logic [1:0] IDLE   = 2'd1;
   localparam logic [1:0] WRITE  = 2'd2;
   localparam logic [1:0] CLRROW = 2'd3;
   localparam int         CELLS  = COLS * ROWS;

   logic [1:0]  state, nxt_state;
   logic [11:0] idx, nxt_idx;
   logic [6:0]  nxt_cx;
   logic [4:0]  nxt_cy, next_row;
   logic        clr_pend, nxt_pend;
   logic        emit;
   logic [11:0] emit_addr, row_base;
   logic [7:0]  emit_byte;

   assign row_base = 12'(cursor_y) * 12'(COLS);
   assign next_row = (cursor_y == 5'(ROWS - 1)) ? '0 : cursor_y + 5'd1;
   assign ch_ready = (state == IDLE) && !clr_req && !clr_pend;
   assign Hwrite   = Hselect;
   assign ready    = Hselect;
   assign Hsize    = 1'b0;

   // Writes are decided here and appear on the registered bus one cycle later;
   // the clear states spend one extra idle cycle after the last index so that
   // the final clear write is on the bus before ch_ready can rise.
   always_comb begin
      nxt_state = state;
      nxt_idx   = idx;
      nxt_cx    = cursor_x;
      nxt_cy    = cursor_y;
      nxt_pend  = clr_pend | clr_req;
      emit      = 1'b0;
      emit_addr = '0;
      emit_byte = '0;
      case (state)
         CLRSCR: begin
            if (idx < 12'(CELLS)) begin
               emit      = 1'b1;
               emit_addr = idx;
               emit_byte = BLANK;
               nxt_idx   = idx + 12'd1;
            end else begin
               nxt_state = IDLE;
               nxt_idx   = '0;
               nxt_cx    = '0;
               nxt_cy    = '0;
            end
         end
         IDLE: begin
            nxt_pend = 1'b0;
            if (clr_req || clr_pend) begin
               nxt_state = CLRSCR;
               nxt_idx   = '0;
            end else if (ch_valid) begin
               if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
                  emit      = 1'b1;
                  emit_addr = row_base + 12'(cursor_x);
                  emit_byte = ch_data;
                  nxt_state = WRITE;
               end else if (ch_data == 8'h0A) begin
                  nxt_cx    = '0;
                  nxt_cy    = next_row;
                  nxt_idx   = '0;
                  nxt_state = CLRROW;
               end else if (ch_data == 8'h0D) begin
                  nxt_cx = '0;
               end else if (ch_data == 8'h08 && cursor_x != '0) begin
                  nxt_cx    = cursor_x - 7'd1;
                  emit      = 1'b1;
                  emit_addr = row_base + 12'(cursor_x - 7'd1);
                  emit_byte = BLANK;
               end
            end
         end
         WRITE: begin
            if (cursor_x == 7'(COLS - 1)) begin
               nxt_cx    = '0;
               nxt_cy    = next_row;
               nxt_idx   = '0;
               nxt_state = CLRROW;
            end else begin
               nxt_cx    = cursor_x + 7'd1;
               nxt_state = IDLE;
            end
         end
         default: begin
            if (idx < 12'(COLS)) begin
               emit      = 1'b1;
               emit_addr = row_base + idx;
               emit_byte = BLANK;
               nxt_idx   = idx + 12'd1;
            end else begin
               nxt_state = IDLE;
               nxt_idx   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge Hclock or negedge Hreset) begin
      if (!Hreset) begin
         state      <= CLRSCR;
         idx        <= '0;
         cursor_x   <= '0;
         cursor_y   <= '0;
         clr_pend   <= 1'b0;
         Hselect    <= 1'b0;
         Haddress   <= '0;
         Hwritedata <= '0;
      end else begin
         state      <= nxt_state;
         idx        <= nxt_idx;
         cursor_x   <= nxt_cx;
         cursor_y   <= nxt_cy;
         clr_pend   <= nxt_pend;
         Hselect    <= emit;
         Haddress   <= emit_addr;
         Hwritedata <= {24'h0, emit_byte};
      end
   end

endmodule
